// File: rtl/stream_apb_pkg.sv
// Shared definitions for the byte-stream to APB bridge: FSM state encoding
// and the byte used to fill read data after a failed access.
package stream_apb_pkg;

    typedef enum logic [2:0] {
        ST_ADDR   = 3'd0,
        ST_WDATA  = 3'd1,
        ST_SETUP  = 3'd2,
        ST_ACCESS = 3'd3,
        ST_RSHIFT = 3'd4
    } state_e;

    localparam logic [7:0] ERR_FILL_BYTE = 8'hFF;

endpackage

// File: rtl/apb_timeout_counter.sv
// Counts ACCESS-phase cycles spent waiting for PREADY and flags the cycle in
// which the wait reaches TIMEOUT cycles.
module apb_timeout_counter #(
    parameter int TIMEOUT = 255
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic load_i,
    input  logic enable_i,
    output logic expire_o
);

    localparam logic [15:0] LIMIT = 16'(TIMEOUT - 1);

    logic [15:0] count_q;

    // Restart at zero in SETUP, then count each waiting ACCESS cycle.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            count_q <= 16'd0;
        end else if (load_i) begin
            count_q <= 16'd0;
        end else if (enable_i && (count_q != LIMIT)) begin
            count_q <= count_q + 16'd1;
        end
    end

    assign expire_o = enable_i && (count_q == LIMIT);

endmodule

// File: rtl/stream_to_apb_wide.sv
// Bridges an I2C-slave byte stream to an APB master with multi-byte address
// and data words. Optional feature: define STREAM_TO_APB_PSLVERR_EN to make
// PSLVERR set the sticky error and replace read data with 0xFF bytes.
module stream_to_apb_wide
    import stream_apb_pkg::*;
#(
    parameter int ADDR_BYTES = 1,
    parameter int DATA_BYTES = 1,
    parameter int AUTO_INC   = 1,
    parameter int TIMEOUT    = 255
) (
    input  logic                    CLK,
    input  logic                    RESETn,
    input  logic [7:0]              in_data,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic                    in_last,
    output logic [7:0]              out_data,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic                    out_last,
    input  logic                    busy,
    output logic                    err,
    output logic                    PSEL,
    output logic                    PENABLE,
    output logic                    PWRITE,
    output logic [8*ADDR_BYTES-1:0] PADDR,
    output logic [8*DATA_BYTES-1:0] PWDATA,
    input  logic [8*DATA_BYTES-1:0] PRDATA,
    input  logic                    PREADY,
    input  logic                    PSLVERR
);

    localparam int AW = 8 * ADDR_BYTES;
    localparam int DW = 8 * DATA_BYTES;
    localparam logic [2:0] AB_M1 = 3'(ADDR_BYTES - 1);
    localparam logic [2:0] DB_M1 = 3'(DATA_BYTES - 1);
    localparam logic [DW-1:0] ERR_FILL = {DATA_BYTES{ERR_FILL_BYTE}};

    state_e        state_q, state_d;
    logic [AW-1:0] addr_q, addr_d;
    logic [DW-1:0] wdata_q, wdata_d;
    logic [DW-1:0] rdata_q, rdata_d;
    logic [2:0]    addrCnt_q, addrCnt_d;
    logic [2:0]    byteCnt_q, byteCnt_d;
    logic [2:0]    rCnt_q, rCnt_d;
    logic          pwrite_q, pwrite_d;
    logic          lastPend_q, lastPend_d;
    logic          abortPend_q, abortPend_d;
    logic          err_q, err_d;
    logic          inReady_q;
    logic          busyPrev_q;

    logic inAccept, busyFall, readReq, accessDone, slvErr, accessFault;
    logic tmoLoad, tmoEnable, tmoExpire;

`ifdef STREAM_TO_APB_PSLVERR_EN
    assign slvErr = PSLVERR;
`else
    logic unusedPslverr;
    assign unusedPslverr = PSLVERR;
    assign slvErr        = 1'b0;
`endif

    assign inAccept    = in_valid && inReady_q;
    assign busyFall    = busyPrev_q && !busy;
    assign readReq     = out_ready && !out_valid && (byteCnt_q == 3'd0) && !in_valid;
    assign accessDone  = PREADY || tmoExpire;
    assign accessFault = tmoExpire || slvErr;

    apb_timeout_counter #(
        .TIMEOUT (TIMEOUT)
    ) u_timeout (
        .clk_i    (CLK),
        .rst_ni   (RESETn),
        .load_i   (tmoLoad),
        .enable_i (tmoEnable),
        .expire_o (tmoExpire)
    );

    // Next-state logic: byte assembly, APB sequencing and read byte shifting.
    always_comb begin
        state_d     = state_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        rdata_d     = rdata_q;
        addrCnt_d   = addrCnt_q;
        byteCnt_d   = byteCnt_q;
        rCnt_d      = rCnt_q;
        pwrite_d    = pwrite_q;
        lastPend_d  = lastPend_q;
        abortPend_d = abortPend_q;
        err_d       = err_q;
        tmoLoad     = 1'b0;
        tmoEnable   = 1'b0;
        case (state_q)
            ST_ADDR: begin
                if (busyFall) begin
                    addrCnt_d = 3'd0;
                end else if (inAccept) begin
                    addr_d = AW'({addr_q, in_data});
                    if (in_last) begin
                        addrCnt_d = 3'd0;
                    end else if (addrCnt_q == AB_M1) begin
                        addrCnt_d = 3'd0;
                        state_d   = ST_WDATA;
                    end else begin
                        addrCnt_d = addrCnt_q + 3'd1;
                    end
                end
            end
            ST_WDATA: begin
                if (busyFall) begin
                    byteCnt_d = 3'd0;
                    state_d   = ST_ADDR;
                end else if (inAccept) begin
                    wdata_d = DW'({wdata_q, in_data});
                    if (byteCnt_q == DB_M1) begin
                        byteCnt_d   = 3'd0;
                        pwrite_d    = 1'b1;
                        lastPend_d  = in_last;
                        abortPend_d = 1'b0;
                        state_d     = ST_SETUP;
                    end else if (in_last) begin
                        byteCnt_d = 3'd0;
                        err_d     = 1'b1;
                        state_d   = ST_ADDR;
                    end else begin
                        byteCnt_d = byteCnt_q + 3'd1;
                    end
                end else if (readReq) begin
                    pwrite_d    = 1'b0;
                    lastPend_d  = 1'b0;
                    abortPend_d = 1'b0;
                    state_d     = ST_SETUP;
                end
            end
            ST_SETUP: begin
                tmoLoad = 1'b1;
                state_d = ST_ACCESS;
                if (busyFall) begin
                    abortPend_d = 1'b1;
                end
            end
            ST_ACCESS: begin
                tmoEnable = 1'b1;
                if (busyFall) begin
                    abortPend_d = 1'b1;
                end
                if (accessDone) begin
                    if (PREADY && (AUTO_INC != 0)) begin
                        addr_d = addr_q + AW'(1);
                    end
                    if (accessFault) begin
                        err_d = 1'b1;
                    end
                    if (!pwrite_q) begin
                        rdata_d = accessFault ? ERR_FILL : PRDATA;
                        rCnt_d  = 3'd0;
                    end
                    if (abortPend_q || busyFall || (pwrite_q && lastPend_q)) begin
                        state_d = ST_ADDR;
                    end else if (pwrite_q) begin
                        state_d = ST_WDATA;
                    end else begin
                        state_d = ST_RSHIFT;
                    end
                end
            end
            ST_RSHIFT: begin
                if (busyFall) begin
                    rCnt_d  = 3'd0;
                    state_d = ST_ADDR;
                end else if (out_ready) begin
                    rdata_d = rdata_q << 8;
                    if (rCnt_q == DB_M1) begin
                        rCnt_d  = 3'd0;
                        state_d = ST_WDATA;
                    end else begin
                        rCnt_d = rCnt_q + 3'd1;
                    end
                end
            end
            default: state_d = ST_ADDR;
        endcase
    end

    // State and datapath registers; reset abandons any APB access in flight.
    always_ff @(posedge CLK) begin
        if (!RESETn) begin
            state_q     <= ST_ADDR;
            addr_q      <= '0;
            wdata_q     <= '0;
            rdata_q     <= '0;
            addrCnt_q   <= 3'd0;
            byteCnt_q   <= 3'd0;
            rCnt_q      <= 3'd0;
            pwrite_q    <= 1'b0;
            lastPend_q  <= 1'b0;
            abortPend_q <= 1'b0;
            err_q       <= 1'b0;
            inReady_q   <= 1'b0;
            busyPrev_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            rdata_q     <= rdata_d;
            addrCnt_q   <= addrCnt_d;
            byteCnt_q   <= byteCnt_d;
            rCnt_q      <= rCnt_d;
            pwrite_q    <= pwrite_d;
            lastPend_q  <= lastPend_d;
            abortPend_q <= abortPend_d;
            err_q       <= err_d;
            inReady_q   <= (state_d == ST_ADDR) || (state_d == ST_WDATA);
            busyPrev_q  <= busy;
        end
    end

    assign in_ready  = inReady_q;
    assign PSEL      = (state_q == ST_SETUP) || (state_q == ST_ACCESS);
    assign PENABLE   = (state_q == ST_ACCESS);
    assign PWRITE    = pwrite_q;
    assign PADDR     = addr_q;
    assign PWDATA    = wdata_q;
    assign out_valid = (state_q == ST_RSHIFT);
    assign out_last  = (state_q == ST_RSHIFT) && (rCnt_q == DB_M1);
    assign out_data  = rdata_q[DW-1 -: 8];
    assign err       = err_q;

endmodule

// File: doc/stream_to_apb_wide.md
STREAM_TO_APB_WIDE -- requirements
Module: stream_to_apb_wide

Interface
REQ-001 SHALL have parameter ADDR_BYTES, default 1: APB address width in bytes (1..4); PADDR width is 8*ADDR_BYTES.
REQ-002 SHALL have parameter DATA_BYTES, default 1: APB data width in bytes (1..4); PWDATA/PRDATA width is 8*DATA_BYTES.
REQ-003 SHALL have parameter AUTO_INC, default 1: 1 = word address increments after each APB access, 0 = address held.
REQ-004 SHALL have parameter TIMEOUT, default 255: maximum access-phase cycles waiting for PREADY (1..65535).
REQ-005 SHALL have ports: CLK in 1, clock; RESETn in 1, reset, synchronous, active-low.
REQ-006 SHALL have ports: in_data in 8, in_valid in 1, in_ready out 1, in_last in 1 (write byte stream from I2C slave).
REQ-007 SHALL have ports: out_data out 8, out_valid out 1, out_ready in 1, out_last out 1 (read byte stream to I2C slave).
REQ-008 SHALL have ports: busy in 1 (I2C transaction active); err out 1 (sticky error).
REQ-009 SHALL have ports: PSEL, PENABLE, PWRITE out 1; PADDR out 8*ADDR_BYTES; PWDATA out 8*DATA_BYTES; PRDATA in 8*DATA_BYTES; PREADY in 1; PSLVERR in 1.

Function
REQ-010 SHALL implement states ADDR, WDATA, SETUP, ACCESS, RSHIFT; ADDR is the post-reset state.
REQ-011 SHALL, in ADDR, take ADDR_BYTES accepted bytes MSB first into the address register, then enter WDATA.
REQ-012 SHALL, in WDATA, take bytes MSB first into the write word; on byte DATA_BYTES of a word, enter SETUP with PWRITE=1.
REQ-013 SHALL hold in_ready high in ADDR/WDATA and low in SETUP/ACCESS/RSHIFT.
REQ-014 SHALL drive PSEL=1,PENABLE=0 in SETUP (exactly one cycle), then PSEL=1,PENABLE=1 in ACCESS until PREADY=1.
REQ-015 SHALL keep PADDR, PWRITE and PWDATA stable across SETUP and ACCESS.
REQ-016 SHALL start a read (SETUP with PWRITE=0) when out_ready=1, out_valid=0, the address phase is complete and the state is WDATA with no partial word.
REQ-017 SHALL, on a read completing (PREADY=1), latch PRDATA, enter RSHIFT and present DATA_BYTES bytes MSB first; out_last=1 on the final byte.
REQ-018 SHALL, after the last RSHIFT byte is taken, return to WDATA; the next out_ready starts another read.
REQ-019 SHALL, when AUTO_INC=1, increment the address by 1 (modulo 2^(8*ADDR_BYTES)) after each completed access.
REQ-020 SHALL, on in_last with a partial word (1..DATA_BYTES-1 bytes), discard the partial word, issue no APB write and set err.
REQ-021 SHALL, after in_last or on busy falling, return to ADDR for the next write byte while retaining the address register, so a repeated-start read uses the last address.
REQ-022 SHALL abort an ACCESS phase reaching TIMEOUT cycles without PREADY: drop PSEL/PENABLE, set err, and return 0xFF bytes for a read.
REQ-023 SHALL, when busy falls mid-RSHIFT, drop out_valid and return to ADDR; an in-flight APB access still completes normally.
REQ-024 SHALL clear err only by reset.

Reset
REQ-025 SHALL, while RESETn=0 at a CLK edge: state=ADDR; address=0; PSEL=PENABLE=PWRITE=0; PADDR=PWDATA=0; in_ready=0; out_valid=out_last=0; out_data=0; err=0.
REQ-026 SHALL abandon any in-flight APB access on reset without completing it.

Configuration
REQ-027 SHALL honour macro STREAM_TO_APB_PSLVERR_EN: when defined, PSLVERR=1 at access completion sets err, and read data is replaced by 0xFF bytes.
REQ-028 SHALL, without STREAM_TO_APB_PSLVERR_EN, ignore PSLVERR entirely.

Structure
REQ-029 SHALL take the state encoding and the 0xFF error-fill constant from shared package stream_apb_pkg.
REQ-030 SHALL contain one sub-module, apb_timeout_counter (load/enable/expire), instantiated once.

Verification
REQ-031 Write (DB=2): bytes 0x10,0xAB,0xCD,last -> one write PADDR=0x10, PWDATA=0xABCD; PENABLE 2 cycles after 0xCD accepted.
REQ-032 Burst write 0x20,0x01,0x02,0x03,0x04 (DB=2) -> writes 0x20=0x0102, 0x21=0x0304.
REQ-033 Address 0x30 then read 4 bytes, PRDATA=0x1234 then 0x5678 -> out 0x12,0x34(last),0x56,0x78(last); reads at 0x30,0x31.
REQ-034 Bytes 0x40,0xAA,last (DB=2) -> no APB write; err=1.
REQ-035 PREADY held low (TIMEOUT=8) on a read -> PSEL drops after 8 access cycles; out 0xFF,0xFF; err=1.
REQ-036 RESETn low during ACCESS -> next cycle PSEL=0, state=ADDR, all outputs at reset values.
